mtm_alu_serializer: RTL and testbench
=====================================

Name: mtm_alu_serializer

Overview:
Result-side serial transmitter of the mtm_Alu link. It takes one ALU response per valid/ready handshake and shifts it out on sout using the same 11-bit frame format as the sin side. Frame format: start 0, type bit, 8 payload bits MSB first, stop 1. Response kinds: a 5-frame result packet (C plus a CRC3-protected control byte) or a 1-frame error packet.

Parameters:
GAP_BITS, 0, idle-high bit times inserted after every stop bit, before the next start bit (0..15).

Ports:
clk  in  1  clock; one serial bit per clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  response present
in_ready  out  1  block can accept a response
in_is_err  in  1  1 = error packet, 0 = result packet
in_c  in  32  result word C
in_flags  in  4  {carry, overflow, zero, negative}
in_err_flags  in  6  error flags
sout  out  1  serial output; idle high
busy  out  1  packet in progress

Behaviour:
- Reset values (rst sampled high at a clk edge): sout=1, busy=0, in_ready=1, FSM=IDLE, all counters and shift registers cleared.
- Reset mid-packet aborts the packet. sout returns to 1 on that edge and nothing is resumed.
- Handshake: accept on in_valid & in_ready at edge N.
  - in_ready=1 only in IDLE.
  - Inputs are captured into an internal packet register at N; later input changes are ignored.
  - in_valid while busy is held off; it is not an error.
- Latency: start bit of the first frame drives sout from edge N+1. Every bit lasts exactly 1 clk.
- Result packet, 5 frames, type bit 0 for the data frames:
  - Frames 1-4 carry C[31:24], C[23:16], C[15:8], C[7:0].
  - Frame 5 has type bit 1 and payload {1'b0, in_flags[3:0], crc3[2:0]}.
- CRC3 generation:
  - Polynomial x^3+x+1, init 000, computed over the 37 bits {C, 1'b0, flags}, MSB first.
  - Per bit d: fb = r[2]^d; r = {r[1], r[0]^fb, fb}.
  - Equivalent to the augmented form with 3 zero bits appended.
  - Computed combinationally or serially, but it must be valid before frame 5 starts.
- Error packet, 1 frame, type bit 1, payload {1'b1, err_flags[5:0], p}. p is even parity over {1'b1, err_flags}, i.e. the XOR of those 7 bits.
- FSM states:
  - IDLE: sout=1. Goes to START on accept.
  - START: sout=0, 1 cycle. Goes to TYPE.
  - TYPE: sout=type, 1 cycle. Goes to DATA.
  - DATA: 8 cycles, bit counter 7 down to 0, sout=payload[cnt]. Goes to STOP.
  - STOP: sout=1, 1 cycle. Goes to GAP if GAP_BITS>0 and frames remain. Otherwise goes to START if frames remain, else IDLE.
  - GAP: sout=1 for GAP_BITS cycles. Goes to START.
- Frame counter 0..4 for result packets, 0 for error packets; it wraps only via IDLE.
- Packet duration:
  - Result packet: 5*11 + 4*GAP_BITS cycles.
  - Error packet: 11 cycles.
  - No gap after the last frame.
  - Earliest next accept is the cycle after the final stop bit (in_ready rises in IDLE).
- busy=1 from START of the first frame through STOP of the last frame.
- sout is driven directly from a flop; no combinational path from inputs to sout.

Optional Feature:
MTM_SER_PKT_CNT_EN
- Defined: adds output ports pkt_cnt[15:0] and err_cnt[15:0].
  - Both reset to 0.
  - pkt_cnt increments on the last stop bit of every packet.
  - err_cnt increments only for error packets.
  - Both wrap 0xFFFF -> 0x0000.
  - A packet aborted by rst is not counted.
- Undefined: ports absent, no counter logic; behaviour otherwise identical.

Decomposition:
- Shared package mtm_alu_pkg:
  - Frame type constants DATA_TYPE=1'b0 and CMD_TYPE=1'b1.
  - Frame length constant 11.
  - Flag bit index constants.
  - typedef enum for serializer FSM states.
  - Function crc3_calc(input [31:0] c, input [3:0] flags).
  - Function err_parity(input [5:0] e).
- One natural sub-module: mtm_alu_frame_tx. It serializes a single {type, byte} frame with start/stop/gap, handles its own handshake, and reports done to a packet-level sequencer in the top.

Test Plan:
- Reset: hold rst 3 cycles during an active packet -> sout=1 from the first reset edge; after release in_ready=1, busy=0, no residual bits.
- Error packet, err_flags=6'b100100, GAP_BITS=0 -> sout sequence 0,1,1,1,0,0,1,0,0,1,1 (payload 0xC9), in_ready back high after 11 cycles.
- Result packet C=32'h66666666, flags=4'b0000 -> four data frames with type 0 and payload 0x66, then control frame type 1 payload {0,0000,crc3}. crc3 must equal the bench model; total 55 cycles.
- GAP_BITS=5, C=32'h24242424, flags=4'b0001 -> exactly 5 idle-high bits between the four inter-frame boundaries, none after the last frame; total 75 cycles.
- Back-to-back: in_valid held high with two queued responses -> second start bit appears exactly 1 cycle after first packet's last stop bit. Input changes during the first packet do not alter its bits.
- MTM_SER_PKT_CNT_EN: send 3 result + 2 error packets, plus one packet aborted by rst -> pkt_cnt=5 and err_cnt=2 only if rst not asserted after them (counters cleared by rst). Wrap check preloads 16'hFFFF by force -> 16'h0000.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// Shared constants, state encoding and check-bit helpers for the mtm_Alu serial link.
package mtm_alu_pkg;

  localparam logic DATA_TYPE = 1'b0;
  localparam logic CMD_TYPE  = 1'b1;
  localparam int   FRAME_LEN = 11;

  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 0;

  localparam int RESULT_FRAMES = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TYPE,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } ser_state_t;

  // CRC3, poly x^3+x+1, init 0, over {c, 1'b0, flags} MSB first
  function automatic logic [2:0] crc3_calc(input logic [31:0] c, input logic [3:0] flags);
    logic [36:0] m;
    logic [2:0]  r;
    logic        fb;
    m = {c, 1'b0, flags};
    r = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = r[2] ^ m[i];
      r  = {r[1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  function automatic logic err_parity(input logic [5:0] e);
    return ^{1'b1, e};
  endfunction

endpackage

// File: rtl/mtm_alu_frame_tx.sv
// Single-frame serializer: start, type, 8 data bits MSB first, stop, optional idle gap.
// Chains frames while frm_more is set; sout and busy come straight from flops.
module mtm_alu_frame_tx
  import mtm_alu_pkg::*;
#(
  parameter int unsigned GAP_BITS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frm_valid,
  output logic       frm_ready,
  input  logic       frm_type,
  input  logic [7:0] frm_byte,
  input  logic       frm_more,
  output logic       frame_done,
  output logic       pkt_done,
  output logic       sout,
  output logic       busy
);

  // state    | meaning
  // ST_IDLE  | line idle high, waiting for a packet
  // ST_START | start bit (0)
  // ST_TYPE  | frame type bit
  // ST_DATA  | payload bits, bit_cnt 7 down to 0
  // ST_STOP  | stop bit (1); decides next frame or end of packet
  // ST_GAP   | idle-high spacing between frames of one packet

  localparam logic [3:0] GAP_LOAD = 4'(GAP_BITS - 1);

  ser_state_t state_q, state_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [3:0] gap_cnt_q, gap_cnt_n;
  logic       sout_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sout      <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      gap_cnt_q <= gap_cnt_n;
      sout      <= sout_n;
      busy      <= (state_q != ST_IDLE);
    end
  end

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    gap_cnt_n  = gap_cnt_q;
    frame_done = 1'b0;
    pkt_done   = 1'b0;
    sout_n     = 1'b1;
    frm_ready  = (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE:  if (frm_valid) state_n = ST_START;
      ST_START: begin
        sout_n  = 1'b0;
        state_n = ST_TYPE;
      end
      ST_TYPE: begin
        sout_n    = frm_type;
        bit_cnt_n = 3'd7;
        state_n   = ST_DATA;
      end
      ST_DATA: begin
        sout_n = frm_byte[bit_cnt_q];
        if (bit_cnt_q == 3'd0) state_n = ST_STOP;
        else bit_cnt_n = bit_cnt_q - 3'd1;
      end
      ST_STOP: begin
        if (frm_more) begin
          frame_done = 1'b1;
          if (GAP_BITS != 0) begin
            gap_cnt_n = GAP_LOAD;
            state_n   = ST_GAP;
          end else begin
            state_n = ST_START;
          end
        end else begin
          pkt_done = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) state_n = ST_START;
        else gap_cnt_n = gap_cnt_q - 4'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Result-side mtm_Alu transmitter: 5-frame result packets or 1-frame error packets.
// Optional packet/error counters are enabled by defining MTM_SER_PKT_CNT_EN.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int unsigned GAP_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_err,
  input  logic [31:0] in_c,
  input  logic [3:0]  in_flags,
  input  logic [5:0]  in_err_flags,
  output logic        sout,
  output logic        busy
`ifdef MTM_SER_PKT_CNT_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
`endif
);

  logic        accept;
  logic        pkt_is_err;
  logic [31:0] pkt_c;
  logic [3:0]  pkt_flags;
  logic [5:0]  pkt_err;
  logic [2:0]  pkt_crc;
  logic        pkt_par;
  logic [2:0]  frame_cnt;
  logic        frm_type;
  logic [7:0]  frm_byte;
  logic        frm_more;
  logic        frame_done;
  logic        pkt_done;

  assign accept = in_valid & in_ready;

  // check bits are computed once at capture so the frame mux stays shallow
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_is_err <= 1'b0;
      pkt_c      <= '0;
      pkt_flags  <= '0;
      pkt_err    <= '0;
      pkt_crc    <= '0;
      pkt_par    <= 1'b0;
      frame_cnt  <= '0;
    end else if (accept) begin
      pkt_is_err <= in_is_err;
      pkt_c      <= in_c;
      pkt_flags  <= in_flags;
      pkt_err    <= in_err_flags;
      pkt_crc    <= crc3_calc(in_c, in_flags);
      pkt_par    <= err_parity(in_err_flags);
      frame_cnt  <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 3'd1;
    end
  end

  always_comb begin
    frm_type = DATA_TYPE;
    frm_byte = pkt_c[31:24];
    frm_more = 1'b0;
    if (pkt_is_err) begin
      frm_type = CMD_TYPE;
      frm_byte = {1'b1, pkt_err, pkt_par};
    end else begin
      case (frame_cnt)
        3'd0: begin frm_byte = pkt_c[31:24]; frm_more = 1'b1; end
        3'd1: begin frm_byte = pkt_c[23:16]; frm_more = 1'b1; end
        3'd2: begin frm_byte = pkt_c[15:8];  frm_more = 1'b1; end
        3'd3: begin frm_byte = pkt_c[7:0];   frm_more = 1'b1; end
        default: begin
          frm_type = CMD_TYPE;
          frm_byte = {1'b0, pkt_flags, pkt_crc};
        end
      endcase
    end
  end

  mtm_alu_frame_tx #(.GAP_BITS(GAP_BITS)) u_frame_tx (
    .clk        (clk),
    .rst        (rst),
    .frm_valid  (in_valid),
    .frm_ready  (in_ready),
    .frm_type   (frm_type),
    .frm_byte   (frm_byte),
    .frm_more   (frm_more),
    .frame_done (frame_done),
    .pkt_done   (pkt_done),
    .sout       (sout),
    .busy       (busy)
  );

`ifdef MTM_SER_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (pkt_done) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (pkt_is_err) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: two instances (GAP_BITS 0 and 5) on shared inputs.
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid0 = 1'b0;
  logic        in_valid5 = 1'b0;
  logic        in_is_err = 1'b0;
  logic [31:0] in_c = '0;
  logic [3:0]  in_flags = '0;
  logic [5:0]  in_err_flags = '0;
  logic        in_ready0, in_ready5, sout0, sout5, busy0, busy5;
`ifdef MTM_SER_PKT_CNT_EN
  logic [15:0] pkt_cnt0, err_cnt0, pkt_cnt5, err_cnt5;
`endif

  int total = 0;
  int bad = 0;
  logic cap [0:127];
  logic rdy [0:127];
  logic bsy [0:127];

  always #5 clk = ~clk;

  mtm_alu_serializer #(.GAP_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_is_err(in_is_err), .in_c(in_c), .in_flags(in_flags), .in_err_flags(in_err_flags),
    .sout(sout0), .busy(busy0)
`ifdef MTM_SER_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt0), .err_cnt(err_cnt0)
`endif
  );

  mtm_alu_serializer #(.GAP_BITS(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_is_err(in_is_err), .in_c(in_c), .in_flags(in_flags), .in_err_flags(in_err_flags),
    .sout(sout5), .busy(busy5)
`ifdef MTM_SER_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt5), .err_cnt(err_cnt5)
`endif
  );

  function automatic logic [10:0] mk_frame(input logic t, input logic [7:0] b);
    return {1'b0, t, b, 1'b1};
  endfunction

  function automatic logic [10:0] got_frame(input int off);
    logic [10:0] r;
    for (int i = 0; i < 11; i++) r[10-i] = cap[off+i];
    return r;
  endfunction

  // called at #1 after an edge with the target instance idle
  task automatic start_pkt(input int sel, input logic is_err, input logic [31:0] c,
                           input logic [3:0] fl, input logic [5:0] ef);
    in_is_err    = is_err;
    in_c         = c;
    in_flags     = fl;
    in_err_flags = ef;
    if (sel == 1) in_valid5 = 1'b1;
    else in_valid0 = 1'b1;
  endtask

  // cap[k] is sout after edge N+1+k, where N is the accept edge
  task automatic run_pkt(input int sel, input int n);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_valid5 = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cap[k] = (sel == 1) ? sout5 : sout0;
      rdy[k] = (sel == 1) ? in_ready5 : in_ready0;
      bsy[k] = (sel == 1) ? busy5 : busy0;
    end
  endtask

  task automatic test_reset();
    int nbad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (sout0 !== 1'b1) begin bad++; $display("FAIL rst_sout0 got=%b exp=1", sout0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy0 got=%b exp=0", busy0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL rst_ready0 got=%b exp=1", in_ready0); end
    total++; if (sout5 !== 1'b1) begin bad++; $display("FAIL rst_sout5 got=%b exp=1", sout5); end
    total++; if (busy5 !== 1'b0) begin bad++; $display("FAIL rst_busy5 got=%b exp=0", busy5); end
    rst = 1'b0;
    @(posedge clk); #1;
    start_pkt(0, 1'b0, 32'h0000_0000, 4'h0, 6'h00);
    run_pkt(0, 15);
    total++; if (cap[13] !== 1'b0) begin bad++; $display("FAIL rst_pre_abort got=%b exp=0", cap[13]); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (sout0 !== 1'b1) begin bad++; $display("FAIL rst_abort_sout cyc=%0d got=%b exp=1", i, sout0); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL rst_rel_ready got=%b exp=1", in_ready0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_rel_busy got=%b exp=0", busy0); end
    nbad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sout0 !== 1'b1 || busy0 !== 1'b0) nbad++;
    end
    total++; if (nbad != 0) begin bad++; $display("FAIL rst_residual bad_cycles=%0d exp=0", nbad); end
  endtask

  task automatic test_err_packet();
    start_pkt(0, 1'b1, 32'hDEAD_BEEF, 4'hF, 6'b100100);
    run_pkt(0, 14);
    total++;
    if (got_frame(0) !== 11'b01110010011) begin
      bad++; $display("FAIL err_frame got=%b exp=%b", got_frame(0), 11'b01110010011);
    end
    total++; if (rdy[9] !== 1'b0) begin bad++; $display("FAIL err_ready_early got=%b exp=0", rdy[9]); end
    total++; if (rdy[10] !== 1'b1) begin bad++; $display("FAIL err_ready_11 got=%b exp=1", rdy[10]); end
    total++; if (bsy[10] !== 1'b1) begin bad++; $display("FAIL err_busy_stop got=%b exp=1", bsy[10]); end
    total++; if (bsy[11] !== 1'b0) begin bad++; $display("FAIL err_busy_end got=%b exp=0", bsy[11]); end
    total++;
    if ({cap[11], cap[12], cap[13]} !== 3'b111) begin
      bad++; $display("FAIL err_trailer got=%b exp=111", {cap[11], cap[12], cap[13]});
    end
  endtask

  task automatic test_result_packet();
    logic [10:0] exp;
    start_pkt(0, 1'b0, 32'h6666_6666, 4'b0000, 6'h3F);
    run_pkt(0, 60);
    for (int f = 0; f < 4; f++) begin
      exp = mk_frame(1'b0, 8'h66);
      total++;
      if (got_frame(11*f) !== exp) begin
        bad++; $display("FAIL res_data%0d got=%b exp=%b", f, got_frame(11*f), exp);
      end
    end
    exp = mk_frame(1'b1, 8'h07);
    total++;
    if (got_frame(44) !== exp) begin bad++; $display("FAIL res_ctrl got=%b exp=%b", got_frame(44), exp); end
    total++; if (rdy[53] !== 1'b0) begin bad++; $display("FAIL res_ready_early got=%b exp=0", rdy[53]); end
    total++; if (rdy[54] !== 1'b1) begin bad++; $display("FAIL res_ready_55 got=%b exp=1", rdy[54]); end
    total++; if (bsy[54] !== 1'b1) begin bad++; $display("FAIL res_busy_stop got=%b exp=1", bsy[54]); end
    total++; if (bsy[55] !== 1'b0) begin bad++; $display("FAIL res_busy_end got=%b exp=0", bsy[55]); end
    total++;
    if ({cap[55], cap[56], cap[57], cap[58], cap[59]} !== 5'b11111) begin
      bad++; $display("FAIL res_trailer got=%b exp=11111", {cap[55], cap[56], cap[57], cap[58], cap[59]});
    end
  endtask

  task automatic test_gap();
    logic [10:0] exp;
    logic [4:0]  g;
    start_pkt(1, 1'b0, 32'h2424_2424, 4'b0001, 6'h00);
    run_pkt(1, 80);
    for (int f = 0; f < 4; f++) begin
      exp = mk_frame(1'b0, 8'h24);
      total++;
      if (got_frame(16*f) !== exp) begin
        bad++; $display("FAIL gap_data%0d got=%b exp=%b", f, got_frame(16*f), exp);
      end
      for (int i = 0; i < 5; i++) g[4-i] = cap[16*f+11+i];
      total++;
      if (g !== 5'b11111) begin bad++; $display("FAIL gap_idle%0d got=%b exp=11111", f, g); end
    end
    exp = mk_frame(1'b1, 8'h0E);
    total++;
    if (got_frame(64) !== exp) begin bad++; $display("FAIL gap_ctrl got=%b exp=%b", got_frame(64), exp); end
    total++; if (rdy[73] !== 1'b0) begin bad++; $display("FAIL gap_ready_early got=%b exp=0", rdy[73]); end
    total++; if (rdy[74] !== 1'b1) begin bad++; $display("FAIL gap_ready_75 got=%b exp=1", rdy[74]); end
    for (int i = 0; i < 5; i++) g[4-i] = cap[75+i];
    total++;
    if (g !== 5'b11111) begin bad++; $display("FAIL gap_trailer got=%b exp=11111", g); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] tail;
    start_pkt(0, 1'b1, 32'h0000_0000, 4'h0, 6'b100100);
    @(posedge clk); #1;
    in_err_flags = 6'b000011;
    in_c         = 32'hFFFF_FFFF;
    in_flags     = 4'hF;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      cap[k] = sout0;
      if (k == 11) in_valid0 = 1'b0;
    end
    total++;
    if (got_frame(0) !== mk_frame(1'b1, 8'hC9)) begin
      bad++; $display("FAIL b2b_first got=%b exp=%b", got_frame(0), mk_frame(1'b1, 8'hC9));
    end
    total++; if (cap[11] !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", cap[11]); end
    total++;
    if (got_frame(12) !== mk_frame(1'b1, 8'h87)) begin
      bad++; $display("FAIL b2b_second got=%b exp=%b", got_frame(12), mk_frame(1'b1, 8'h87));
    end
    for (int i = 0; i < 7; i++) tail[6-i] = cap[23+i];
    total++;
    if (tail !== 7'h7F) begin bad++; $display("FAIL b2b_trailer got=%b exp=1111111", tail); end
  endtask

`ifdef MTM_SER_PKT_CNT_EN
  task automatic test_pkt_cnt();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    start_pkt(0, 1'b0, 32'h1234_5678, 4'h2, 6'h00);
    run_pkt(0, 20);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    total++; if (pkt_cnt0 !== 16'd0) begin bad++; $display("FAIL cnt_abort got=%0d exp=0", pkt_cnt0); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      start_pkt(0, 1'b0, 32'hA5A5_0000 + i, 4'h1, 6'h00);
      run_pkt(0, 56);
    end
    for (int i = 0; i < 2; i++) begin
      start_pkt(0, 1'b1, 32'h0, 4'h0, 6'h01 + 6'(i));
      run_pkt(0, 12);
    end
    total++; if (pkt_cnt0 !== 16'd5) begin bad++; $display("FAIL cnt_pkt got=%0d exp=5", pkt_cnt0); end
    total++; if (err_cnt0 !== 16'd2) begin bad++; $display("FAIL cnt_err got=%0d exp=2", err_cnt0); end
    force dut0.pkt_cnt_q = 16'hFFFF;
    force dut0.err_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut0.pkt_cnt_q;
    release dut0.err_cnt_q;
    start_pkt(0, 1'b1, 32'h0, 4'h0, 6'h2A);
    run_pkt(0, 12);
    total++; if (pkt_cnt0 !== 16'h0000) begin bad++; $display("FAIL cnt_pkt_wrap got=%h exp=0000", pkt_cnt0); end
    total++; if (err_cnt0 !== 16'h0000) begin bad++; $display("FAIL cnt_err_wrap got=%h exp=0000", err_cnt0); end
  endtask
`endif

  initial begin
    test_reset();
    test_err_packet();
    test_result_packet();
    test_gap();
    test_back_to_back();
`ifdef MTM_SER_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
